// File: rtl/ivs_rr_onehot_sel.sv
// Registered one-hot request selector with a sticky valid/ack grant.
// Define IVS_SEL_RR_EN for round-robin selection; otherwise the lowest set index always wins.
module ivs_rr_onehot_sel #(
    parameter int N = 32,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          gnt_ack,
    output logic          gnt_vld,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    onehot_q, onehot_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [N-1:0]    cand;
    logic            pick_found;
    logic [IW-1:0]   pick_idx;

`ifdef IVS_SEL_RR_EN
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   nxt_ptr;
    logic [IW-1:0]   pick_ptr;
    logic [N-1:0]    upper;

    // An accepted grant moves the pointer past the granted bit; non-power-of-2 N wraps explicitly.
    assign nxt_ptr  = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    assign pick_ptr = (state_q == GRANT) ? nxt_ptr : ptr_q;
    assign upper    = req & ({N{1'b1}} << pick_ptr);
    assign cand     = (|upper) ? upper : req;
`else
    assign cand     = req;
`endif

    // Scan downwards so the lowest set bit of cand is the last one written.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                pick_found = 1'b1;
                pick_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block is assigned a default first, so no latch can be inferred.
        state_d  = state_q;
        onehot_d = onehot_q;
        idx_d    = idx_q;
`ifdef IVS_SEL_RR_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d  = GRANT;
                    onehot_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    idx_d    = pick_idx;
                end
            end
            GRANT: begin
                if (gnt_ack) begin
`ifdef IVS_SEL_RR_EN
                    ptr_d = nxt_ptr;
`endif
                    if (pick_found) begin
                        onehot_d = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                        idx_d    = pick_idx;
                    end else begin
                        state_d  = IDLE;
                        onehot_d = '0;
                        idx_d    = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            onehot_q <= '0;
            idx_q    <= '0;
`ifdef IVS_SEL_RR_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            onehot_q <= onehot_d;
            idx_q    <= idx_d;
`ifdef IVS_SEL_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign gnt_vld    = (state_q == GRANT);
    assign gnt_onehot = onehot_q;
    assign gnt_idx    = idx_q;

endmodule

// File: tb/tb_ivs_rr_onehot_sel.sv
// Directed bench for ivs_rr_onehot_sel at N=8 (table), N=5 (wrap) and N=64 (sweep).
module tb_ivs_rr_onehot_sel;

`ifdef IVS_SEL_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       rst8 = 1'b1, ack8 = 1'b0, vld8;
    logic [7:0] req8 = '0, oh8;
    logic [2:0] idx8;

    logic       rst5 = 1'b1, ack5 = 1'b0, vld5;
    logic [4:0] req5 = '0, oh5;
    logic [2:0] idx5;

    logic        rst64 = 1'b1, ack64 = 1'b0, vld64;
    logic [63:0] req64 = '0, oh64;
    logic [5:0]  idx64;

    ivs_rr_onehot_sel #(.N(8)) u8 (
        .clk(clk), .rst(rst8), .req(req8), .gnt_ack(ack8),
        .gnt_vld(vld8), .gnt_onehot(oh8), .gnt_idx(idx8));

    ivs_rr_onehot_sel #(.N(5)) u5 (
        .clk(clk), .rst(rst5), .req(req5), .gnt_ack(ack5),
        .gnt_vld(vld5), .gnt_onehot(oh5), .gnt_idx(idx5));

    ivs_rr_onehot_sel #(.N(64)) u64 (
        .clk(clk), .rst(rst64), .req(req64), .gnt_ack(ack64),
        .gnt_vld(vld64), .gnt_onehot(oh64), .gnt_idx(idx64));

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       ack;
        logic       vld;
        logic [2:0] idx;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic a,
                       input logic v, input logic [2:0] i);
        vec_t e;
        e.rst = r; e.req = q; e.ack = a; e.vld = v; e.idx = i;
        tbl.push_back(e);
    endtask

    initial begin
        logic [63:0] exp_oh;

        // Reset and idle ack pulses.
        add(1, 8'h00, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0);
        // Rotation over 1010_0101 with ack held high.
        add(0, 8'hA5, 0, 1, 0);
        add(0, 8'hA5, 1, 1, RR ? 3'd2 : 3'd0);
        add(0, 8'hA5, 1, 1, RR ? 3'd5 : 3'd0);
        add(0, 8'hA5, 1, 1, RR ? 3'd7 : 3'd0);
        add(0, 8'hA5, 1, 1, 3'd0);
        add(0, 8'hA5, 1, 1, RR ? 3'd2 : 3'd0);
        // Sticky hold of idx 3 while req changes, then release to IDLE.
        add(1, 8'h00, 0, 0, 0);
        add(0, 8'h08, 0, 1, 3);
        add(0, 8'h80, 0, 1, 3);
        add(0, 8'h80, 0, 1, 3);
        add(0, 8'h00, 0, 1, 3);
        add(0, 8'h00, 0, 1, 3);
        add(0, 8'h00, 0, 1, 3);
        add(0, 8'h00, 1, 0, 0);
        add(0, 8'h00, 0, 0, 0);
        // Reset dominating an ack: pointer must not advance.
        add(1, 8'h00, 0, 0, 0);
        add(0, 8'h40, 0, 1, 6);
        add(1, 8'h40, 1, 0, 0);
        add(0, 8'hC0, 0, 1, 6);
        add(0, 8'hC0, 1, 1, RR ? 3'd7 : 3'd6);

        foreach (tbl[k]) begin
            rst8 = tbl[k].rst;
            req8 = tbl[k].req;
            ack8 = tbl[k].ack;
            step();
            exp_oh = tbl[k].vld ? (64'd1 << tbl[k].idx) : 64'd0;
            check($sformatf("n8_vec%0d_vld", k), {63'd0, vld8}, {63'd0, tbl[k].vld});
            check($sformatf("n8_vec%0d_idx", k), {61'd0, idx8}, {61'd0, tbl[k].idx});
            check($sformatf("n8_vec%0d_onehot", k), {56'd0, oh8}, exp_oh);
        end

        // N=5 wrap: accepting idx 4 must bring the pointer back to 0.
        rst5 = 1'b1; step();
        rst5 = 1'b0; req5 = 5'b10001; ack5 = 1'b0; step();
        check("n5_first_idx", {61'd0, idx5}, 64'd0);
        check("n5_first_vld", {63'd0, vld5}, 64'd1);
        ack5 = 1'b1; step();
        check("n5_second_idx", {61'd0, idx5}, RR ? 64'd4 : 64'd0);
        check("n5_second_onehot", {59'd0, oh5}, RR ? 64'h10 : 64'h01);
        step();
        check("n5_wrap_idx", {61'd0, idx5}, 64'd0);
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("n5_idx_range_c%0d", c), {63'd0, (idx5 <= 3'd4)}, 64'd1);
            check($sformatf("n5_onehot_c%0d", c), {59'd0, oh5}, 64'd1 << idx5);
        end
        ack5 = 1'b0; req5 = '0;

        // N=64 single-bit sweep: grant exactly one edge after the request appears.
        rst64 = 1'b1; step();
        rst64 = 1'b0;
        for (int i = 0; i < 64; i++) begin
            check($sformatf("n64_pre%0d_vld", i), {63'd0, vld64}, 64'd0);
            req64 = 64'd1 << i; ack64 = 1'b0; step();
            check($sformatf("n64_bit%0d_vld", i), {63'd0, vld64}, 64'd1);
            check($sformatf("n64_bit%0d_idx", i), {58'd0, idx64}, 64'(i));
            check($sformatf("n64_bit%0d_onehot", i), oh64, 64'd1 << i);
            req64 = '0; ack64 = 1'b1; step();
        end
        ack64 = 1'b0;
        check("n64_final_idle", {63'd0, vld64}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
